// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and types for the register-file hazard scoreboard.
package rf_scoreboard_pkg;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int CNT_W    = 2;
    localparam int STAT_W   = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(3);

endpackage

// File: rtl/rf_scoreboard_entry.sv
// Outstanding-write counter for one register-file entry.
module rf_sb_entry
    import rf_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_flush,
    input  logic i_inc,
    input  logic i_wbhit,
    output cnt_t o_count,
    output logic o_pend,
    output logic o_wb_err
);

    cnt_t r_count;
    logic w_dec;

    // A write-back to an idle entry is a protocol error and does not count down.
    assign w_dec    = i_wbhit & (r_count != '0);
    assign o_wb_err = i_wbhit & (r_count == '0) & ~i_flush;
    assign o_pend   = (r_count != '0);
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_count <= '0;
        end else if (i_inc && !w_dec) begin
            r_count <= r_count + cnt_t'(1);
        end else if (!i_inc && w_dec) begin
            r_count <= r_count - cnt_t'(1);
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// RAW/WAW hazard controller with same-cycle write-back forwarding flags.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_rs1,
    input  logic                id_rs1_used,
    input  logic [ADDR_W-1:0]   id_rs2,
    input  logic                id_rs2_used,
    input  logic [ADDR_W-1:0]   id_rd,
    input  logic                id_rd_write,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic                stall,
    output logic                fwd1,
    output logic                fwd2,
    output logic [NUM_REGS-1:0] busy,
    output logic                err,
    output logic [STAT_W-1:0]   stall_cnt
);

    cnt_t                w_count [NUM_REGS];
    logic [NUM_REGS-1:0] w_wbhit;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_pend;
    logic [NUM_REGS-1:0] w_last;
    logic [NUM_REGS-1:0] w_full;
    logic [NUM_REGS-1:0] w_zero_wb;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_issue;

    logic                r_err;
    logic [STAT_W-1:0]   r_stall_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            assign w_wbhit[gi] = wb_valid & (wb_addr == reg_addr_t'(gi));
            assign w_inc[gi]   = w_issue & id_rd_write & (id_rd == reg_addr_t'(gi));
            // The final outstanding write retiring now: operand comes from WB data.
            assign w_last[gi]  = (w_count[gi] == cnt_t'(1)) & w_wbhit[gi];
            assign w_full[gi]  = (w_count[gi] == CNT_MAX);

            rf_sb_entry u_entry (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_flush  (flush),
                .i_inc    (w_inc[gi]),
                .i_wbhit  (w_wbhit[gi]),
                .o_count  (w_count[gi]),
                .o_pend   (w_pend[gi]),
                .o_wb_err (w_zero_wb[gi])
            );
        end
    endgenerate

    assign w_raw1  = id_valid & id_rs1_used & w_pend[id_rs1] & ~w_last[id_rs1];
    assign w_raw2  = id_valid & id_rs2_used & w_pend[id_rs2] & ~w_last[id_rs2];
    assign w_waw   = id_valid & id_rd_write & w_full[id_rd] & ~w_wbhit[id_rd];

    assign stall   = ~flush & (w_raw1 | w_raw2 | w_waw);
    assign w_issue = id_valid & ~stall & ~flush;
    assign fwd1    = id_valid & id_rs1_used & w_last[id_rs1] & ~flush;
    assign fwd2    = id_valid & id_rs2_used & w_last[id_rs2] & ~flush;
    assign busy    = w_pend;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (|w_zero_wb) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {STAT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed-vector bench for rf_scoreboard; one line per checked transaction.
module tb_rf_scoreboard;
    import rf_scoreboard_pkg::*;

    logic                clk;
    logic                reset_n;
    logic                flush;
    logic                id_valid;
    logic [ADDR_W-1:0]   id_rs1;
    logic                id_rs1_used;
    logic [ADDR_W-1:0]   id_rs2;
    logic                id_rs2_used;
    logic [ADDR_W-1:0]   id_rd;
    logic                id_rd_write;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic                stall;
    logic                fwd1;
    logic                fwd2;
    logic [NUM_REGS-1:0] busy;
    logic                err;
    logic [STAT_W-1:0]   stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [STAT_W-1:0] exp_sc = '0;

    rf_scoreboard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_write (id_rd_write),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .stall       (stall),
        .fwd1        (fwd1),
        .fwd2        (fwd2),
        .busy        (busy),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        flush = 0; id_valid = 0; id_rs1 = 0; id_rs1_used = 0;
        id_rs2 = 0; id_rs2_used = 0; id_rd = 0; id_rd_write = 0;
        wb_valid = 0; wb_addr = 0;
    endtask

    // Advance past a rising edge, counting it if stall was high going in.
    task automatic tick();
        if (stall === 1'b1 && exp_sc != '1) exp_sc = exp_sc + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        tick(); tick();
        exp_sc = '0;
        n_total++;
        if (busy !== 4'b0000 || err !== 1'b0 || stall_cnt !== 16'd0 || stall !== 1'b0) begin
            $display("FAIL reset_state: busy=%b err=%b stall_cnt=%0d stall=%b required busy=0000 err=0 stall_cnt=0 stall=0",
                     busy, err, stall_cnt, stall);
        end else begin
            n_pass++;
            $display("ok   reset_state");
        end
        reset_n = 1;
        id_valid = 1; id_rs1 = 1; id_rs1_used = 1; id_rs2 = 2; id_rs2_used = 1;
        settle();
        n_total++;
        if (stall !== 0 || fwd1 !== 0 || fwd2 !== 0 || busy !== 4'b0000 || stall_cnt !== 16'd0) begin
            $display("FAIL idle_read: stall=%b fwd1=%b fwd2=%b busy=%b stall_cnt=%0d required 0 0 0 0000 0",
                     stall, fwd1, fwd2, busy, stall_cnt);
        end else begin
            n_pass++;
            $display("ok   idle_read");
        end
        tick();
        idle();
    endtask

    task automatic test_raw_fwd();
        id_valid = 1; id_rd = 2; id_rd_write = 1;
        settle();
        tick();
        idle();
        id_valid = 1; id_rs1 = 2; id_rs1_used = 1;
        settle();
        n_total++;
        if (stall !== 1'b1 || busy !== 4'b0100) begin
            $display("FAIL raw_stall: stall=%b busy=%b required stall=1 busy=0100", stall, busy);
        end else begin
            n_pass++;
            $display("ok   raw_stall");
        end
        tick(); tick();
        n_total++;
        if (stall_cnt !== exp_sc) begin
            $display("FAIL raw_stall_cnt: got %0d required %0d", stall_cnt, exp_sc);
        end else begin
            n_pass++;
            $display("ok   raw_stall_cnt=%0d", stall_cnt);
        end
        wb_valid = 1; wb_addr = 2;
        settle();
        n_total++;
        if (stall !== 1'b0 || fwd1 !== 1'b1 || fwd2 !== 1'b0) begin
            $display("FAIL raw_fwd: stall=%b fwd1=%b fwd2=%b required 0 1 0", stall, fwd1, fwd2);
        end else begin
            n_pass++;
            $display("ok   raw_fwd");
        end
        tick();
        idle();
        settle();
        n_total++;
        if (busy !== 4'b0000) begin
            $display("FAIL raw_retire: busy=%b required 0000", busy);
        end else begin
            n_pass++;
            $display("ok   raw_retire");
        end
    endtask

    task automatic test_waw();
        for (int i = 0; i < 3; i++) begin
            id_valid = 1; id_rd = 3; id_rd_write = 1;
            settle();
            tick();
        end
        settle();
        n_total++;
        if (stall !== 1'b1 || busy !== 4'b1000) begin
            $display("FAIL waw_stall: stall=%b busy=%b required stall=1 busy=1000", stall, busy);
        end else begin
            n_pass++;
            $display("ok   waw_stall");
        end
        tick(); tick();
        n_total++;
        if (stall_cnt !== exp_sc) begin
            $display("FAIL waw_stall_cnt: got %0d required %0d", stall_cnt, exp_sc);
        end else begin
            n_pass++;
            $display("ok   waw_stall_cnt=%0d", stall_cnt);
        end
        wb_valid = 1; wb_addr = 3;
        settle();
        n_total++;
        if (stall !== 1'b0) begin
            $display("FAIL waw_wb_release: stall=%b required 0", stall);
        end else begin
            n_pass++;
            $display("ok   waw_wb_release");
        end
        tick();
        wb_valid = 0;
        settle();
        n_total++;
        if (stall !== 1'b1 || busy !== 4'b1000) begin
            $display("FAIL waw_count_held: stall=%b busy=%b required stall=1 busy=1000", stall, busy);
        end else begin
            n_pass++;
            $display("ok   waw_count_held");
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_addr = 3;
            settle();
            tick();
        end
        idle();
        settle();
        n_total++;
        if (busy !== 4'b0000 || err !== 1'b0) begin
            $display("FAIL waw_drain: busy=%b err=%b required busy=0000 err=0", busy, err);
        end else begin
            n_pass++;
            $display("ok   waw_drain");
        end
    endtask

    task automatic test_back_to_back();
        id_valid = 1; id_rd = 1; id_rd_write = 1;
        settle();
        tick();
        wb_valid = 1; wb_addr = 1;
        settle();
        tick();
        idle();
        settle();
        n_total++;
        if (busy !== 4'b0010) begin
            $display("FAIL inc_dec_same: busy=%b required 0010", busy);
        end else begin
            n_pass++;
            $display("ok   inc_dec_same");
        end
        wb_valid = 1; wb_addr = 1;
        settle();
        tick();
        idle();
        settle();
        n_total++;
        if (busy !== 4'b0000 || err !== 1'b0) begin
            $display("FAIL inc_dec_drain: busy=%b err=%b required busy=0000 err=0", busy, err);
        end else begin
            n_pass++;
            $display("ok   inc_dec_drain");
        end
    endtask

    task automatic test_err();
        wb_valid = 1; wb_addr = 0;
        settle();
        tick();
        idle();
        settle();
        n_total++;
        if (err !== 1'b1) begin
            $display("FAIL err_set: err=%b required 1", err);
        end else begin
            n_pass++;
            $display("ok   err_set");
        end
        id_valid = 1; id_rd = 2; id_rd_write = 1;
        settle();
        tick();
        idle();
        wb_valid = 1; wb_addr = 2;
        settle();
        tick();
        idle();
        settle();
        n_total++;
        if (err !== 1'b1 || busy !== 4'b0000) begin
            $display("FAIL err_sticky: err=%b busy=%b required err=1 busy=0000", err, busy);
        end else begin
            n_pass++;
            $display("ok   err_sticky");
        end
    endtask

    task automatic test_same_src_fwd();
        id_valid = 1; id_rd = 0; id_rd_write = 1;
        settle();
        tick();
        idle();
        id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
        wb_valid = 1; wb_addr = 1;
        settle();
        n_total++;
        if (stall !== 1'b1 || fwd1 !== 1'b0 || fwd2 !== 1'b0) begin
            $display("FAIL other_wb_no_fwd: stall=%b fwd1=%b fwd2=%b required 1 0 0", stall, fwd1, fwd2);
        end else begin
            n_pass++;
            $display("ok   other_wb_no_fwd");
        end
        wb_addr = 0;
        settle();
        n_total++;
        if (stall !== 1'b0 || fwd1 !== 1'b1 || fwd2 !== 1'b1) begin
            $display("FAIL same_src_fwd: stall=%b fwd1=%b fwd2=%b required 0 1 1", stall, fwd1, fwd2);
        end else begin
            n_pass++;
            $display("ok   same_src_fwd");
        end
        tick();
        idle();
        settle();
        n_total++;
        if (busy !== 4'b0000 || stall_cnt !== exp_sc) begin
            $display("FAIL same_src_retire: busy=%b stall_cnt=%0d required busy=0000 stall_cnt=%0d",
                     busy, stall_cnt, exp_sc);
        end else begin
            n_pass++;
            $display("ok   same_src_retire");
        end
    endtask

    task automatic test_flush();
        id_valid = 1; id_rd = 1; id_rd_write = 1;
        settle();
        tick();
        id_rd = 3;
        settle();
        tick();
        idle();
        id_valid = 1; id_rs2 = 3; id_rs2_used = 1;
        settle();
        n_total++;
        if (stall !== 1'b1 || busy !== 4'b1010) begin
            $display("FAIL flush_pre: stall=%b busy=%b required stall=1 busy=1010", stall, busy);
        end else begin
            n_pass++;
            $display("ok   flush_pre");
        end
        tick();
        flush = 1;
        id_rs1 = 1; id_rs1_used = 1;
        wb_valid = 1; wb_addr = 1;
        settle();
        n_total++;
        if (stall !== 1'b0 || fwd1 !== 1'b0 || fwd2 !== 1'b0) begin
            $display("FAIL flush_cycle: stall=%b fwd1=%b fwd2=%b required 0 0 0", stall, fwd1, fwd2);
        end else begin
            n_pass++;
            $display("ok   flush_cycle");
        end
        tick();
        idle();
        settle();
        n_total++;
        if (busy !== 4'b0000 || err !== 1'b1 || stall_cnt !== exp_sc) begin
            $display("FAIL flush_after: busy=%b err=%b stall_cnt=%0d required busy=0000 err=1 stall_cnt=%0d",
                     busy, err, stall_cnt, exp_sc);
        end else begin
            n_pass++;
            $display("ok   flush_after");
        end
        reset_n = 0;
        tick();
        reset_n = 1;
        exp_sc = '0;
        settle();
        n_total++;
        if (err !== 1'b0 || stall_cnt !== 16'd0 || busy !== 4'b0000) begin
            $display("FAIL reset_clears: err=%b stall_cnt=%0d busy=%b required 0 0 0000", err, stall_cnt, busy);
        end else begin
            n_pass++;
            $display("ok   reset_clears");
        end
    endtask

    initial begin
        idle();
        reset_n = 0;
        test_reset();
        test_raw_fwd();
        test_waw();
        test_back_to_back();
        test_err();
        test_same_src_fwd();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
